// File: rtl/phy_pkg.sv
// phy_pkg: shared constants for the USB full-speed PHY receive path.
//   - Line-state encodings of the registered {D+, D-} pair (J/K/SE0/SE1).
//   - Receive FSM state codes.
//   - Bit-stuffing run length and byte width.
package phy_pkg;

    localparam int STUFF_LEN = 6;
    localparam int BYTE_W    = 8;

    // {d0, d1} = {D+, D-}
    typedef logic [1:0] line_t;
    localparam line_t LINE_SE0 = 2'b00;
    localparam line_t LINE_K   = 2'b01;
    localparam line_t LINE_J   = 2'b10;
    localparam line_t LINE_SE1 = 2'b11;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t ST_IDLE     = 3'd0;
    localparam rx_state_t ST_SYNC     = 3'd1;
    localparam rx_state_t ST_DATA     = 3'd2;
    localparam rx_state_t ST_ERR      = 3'd3;
    localparam rx_state_t ST_EOP_WAIT = 3'd4;

endpackage

// File: rtl/phy_rx_if.sv
// phy_rx_if: byte-level receive interface from the PHY to the link/SIE layer.
//   rx_active : high from SYNC accept until EOP/error recovery completes
//   rx_valid  : one-cycle pulse, rx_data valid
//   rx_sop    : first byte of packet (qualified by rx_valid)
//   rx_eop    : last byte of packet (qualified by rx_valid)
//   rx_data   : received byte, bit0 = first bit on the wire
//   rx_err    : one-cycle pulse, stuff error or non-byte-aligned EOP
// Modports: master = PHY (drives), slave = consumer.
interface phy_rx_if;
    import phy_pkg::*;

    logic              rx_active;
    logic              rx_valid;
    logic              rx_sop;
    logic              rx_eop;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_err;

    modport master (
        output rx_active, rx_valid, rx_sop, rx_eop, rx_data, rx_err
    );

    modport slave (
        input rx_active, rx_valid, rx_sop, rx_eop, rx_data, rx_err
    );

endinterface

// File: rtl/phy_rx_bit_sync.sv
// phy_rx_bit_sync: line input conditioning and bit recovery.
//   Registers the {D+, D-} pair (optionally through a 2-flop synchronizer when
//   RX_SYNC_FF_EN is defined), runs a phase counter that realigns on every
//   line-state change, raises bit_strobe mid-bit and NRZI-decodes the sample.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   r_d0, r_d1    : raw line D+ / D-
//   rx_bit        : NRZI-decoded bit (valid while bit_strobe is high)
//   bit_strobe    : one-cycle sample strobe
//   line_state    : registered line state
module phy_rx_bit_sync
    import phy_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  r_d0,
    input  logic  r_d1,
    output logic  rx_bit,
    output logic  bit_strobe,
    output line_t line_state
);

    localparam int PW = $clog2(CLK_PER_BIT);

    line_t          line_in;
    line_t          line_reg;
    line_t          prev_reg;
    logic [PW-1:0]  phase_reg;

`ifdef RX_SYNC_FF_EN
    line_t meta_reg;
    line_t sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= LINE_J;
            sync_reg <= LINE_J;
        end else begin
            meta_reg <= {r_d0, r_d1};
            sync_reg <= meta_reg;
        end
    end

    assign line_in = sync_reg;
`else
    assign line_in = {r_d0, r_d1};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            line_reg  <= LINE_J;
            prev_reg  <= LINE_J;
            phase_reg <= '0;
        end else begin
            line_reg <= line_in;
            // Phase 0 is the first cycle a new line state is visible in line_reg.
            if (line_in != line_reg) begin
                phase_reg <= '0;
            end else if (phase_reg == PW'(CLK_PER_BIT - 1)) begin
                phase_reg <= '0;
            end else begin
                phase_reg <= phase_reg + PW'(1);
            end
            if (bit_strobe) begin
                prev_reg <= line_reg;
            end
        end
    end

    assign bit_strobe = (phase_reg == PW'(CLK_PER_BIT / 2));
    // NRZI: no transition = 1, transition = 0.
    assign rx_bit     = (line_reg == prev_reg);
    assign line_state = line_reg;

endmodule

// File: rtl/phy_rx.sv
// phy_rx: USB 1.1 full-speed PHY receive path.
//   SYNC detection, bit de-stuffing, LSB-first byte assembly and a one-byte
//   hold register so the last byte of a packet can be tagged with rx_eop.
//   Optional macro RX_SYNC_FF_EN adds a 2-flop input synchronizer (+2 cycles).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   r_d0, r_d1 : line D+ / D-
//   rx         : phy_rx_if.master byte interface (active/valid/sop/eop/data/err)
module phy_rx
    import phy_pkg::*;
#(
    parameter int CLK_PER_BIT    = 4,
    parameter int SYNC_MIN_ZEROS = 6
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      r_d0,
    input  logic      r_d1,
    phy_rx_if.master  rx
);

    logic  rx_bit;
    logic  bit_strobe;
    line_t line_state;

    phy_rx_bit_sync #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_bit_sync (
        .clk        (clk),
        .rst        (rst),
        .r_d0       (r_d0),
        .r_d1       (r_d1),
        .rx_bit     (rx_bit),
        .bit_strobe (bit_strobe),
        .line_state (line_state)
    );

    rx_state_t         state_reg,      state_next;
    logic [7:0]        zero_cnt_reg,   zero_cnt_next;
    logic [2:0]        ones_cnt_reg,   ones_cnt_next;
    logic [2:0]        bit_cnt_reg,    bit_cnt_next;
    logic [BYTE_W-1:0] shift_reg,      shift_next;
    logic [BYTE_W-1:0] hold_reg,       hold_next;
    logic              hold_valid_reg, hold_valid_next;
    logic              first_reg,      first_next;
    logic              se0_seen_reg,   se0_seen_next;
    logic              active_reg,     active_next;
    logic              valid_reg,      valid_next;
    logic              sop_reg,        sop_next;
    logic              eop_reg,        eop_next;
    logic              err_reg,        err_next;
    logic [BYTE_W-1:0] data_reg,       data_next;
    logic [BYTE_W-1:0] new_byte;

    assign new_byte = {rx_bit, shift_reg[BYTE_W-1:1]};

    always_comb begin
        state_next      = state_reg;
        zero_cnt_next   = zero_cnt_reg;
        ones_cnt_next   = ones_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        first_next      = first_reg;
        se0_seen_next   = se0_seen_reg;
        active_next     = active_reg;
        valid_next      = 1'b0;
        sop_next        = 1'b0;
        eop_next        = 1'b0;
        err_next        = 1'b0;
        data_next       = data_reg;

        if (bit_strobe) begin
            case (state_reg)
                ST_IDLE: begin
                    // The first K after idle J is itself a decoded 0 of SYNC.
                    if (line_state == LINE_K) begin
                        state_next    = ST_SYNC;
                        zero_cnt_next = 8'd1;
                    end
                end

                ST_SYNC: begin
                    if (line_state == LINE_SE0 || line_state == LINE_SE1) begin
                        state_next = ST_IDLE;
                    end else if (!rx_bit) begin
                        if (zero_cnt_reg != 8'hFF) begin
                            zero_cnt_next = zero_cnt_reg + 8'd1;
                        end
                    end else if (zero_cnt_reg >= 8'(SYNC_MIN_ZEROS)) begin
                        state_next      = ST_DATA;
                        active_next     = 1'b1;
                        ones_cnt_next   = 3'd1;   // SYNC's final 1 starts the stuff run
                        bit_cnt_next    = 3'd0;
                        hold_valid_next = 1'b0;
                        first_next      = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end

                ST_DATA: begin
                    if (line_state == LINE_SE0) begin
                        if (hold_valid_reg) begin
                            valid_next = 1'b1;
                            data_next  = hold_reg;
                            sop_next   = first_reg;
                            eop_next   = 1'b1;
                        end
                        // EOP in the middle of a byte: partial bits are lost.
                        if (bit_cnt_reg != 3'd0) begin
                            err_next = 1'b1;
                        end
                        hold_valid_next = 1'b0;
                        state_next      = ST_EOP_WAIT;
                    end else if (line_state == LINE_SE1 ||
                                 (ones_cnt_reg == 3'(STUFF_LEN) && rx_bit)) begin
                        state_next      = ST_ERR;
                        err_next        = 1'b1;
                        hold_valid_next = 1'b0;
                        se0_seen_next   = 1'b0;
                    end else if (ones_cnt_reg == 3'(STUFF_LEN)) begin
                        // Stuffed 0: drop it, restart the run.
                        ones_cnt_next = 3'd0;
                    end else begin
                        shift_next    = new_byte;
                        ones_cnt_next = rx_bit ? ones_cnt_reg + 3'd1 : 3'd0;
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'(BYTE_W - 1)) begin
                            // Byte complete: release the previously held one.
                            if (hold_valid_reg) begin
                                valid_next = 1'b1;
                                data_next  = hold_reg;
                                sop_next   = first_reg;
                                first_next = 1'b0;
                            end
                            hold_next       = new_byte;
                            hold_valid_next = 1'b1;
                        end
                    end
                end

                ST_ERR: begin
                    if (line_state == LINE_SE0) begin
                        se0_seen_next = 1'b1;
                    end else if (se0_seen_reg && line_state == LINE_J) begin
                        state_next  = ST_IDLE;
                        active_next = 1'b0;
                    end
                end

                ST_EOP_WAIT: begin
                    if (line_state == LINE_J) begin
                        state_next  = ST_IDLE;
                        active_next = 1'b0;
                    end
                end

                default: begin
                    state_next  = ST_IDLE;
                    active_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            zero_cnt_reg   <= '0;
            ones_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            first_reg      <= 1'b0;
            se0_seen_reg   <= 1'b0;
            active_reg     <= 1'b0;
            valid_reg      <= 1'b0;
            sop_reg        <= 1'b0;
            eop_reg        <= 1'b0;
            err_reg        <= 1'b0;
            data_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            zero_cnt_reg   <= zero_cnt_next;
            ones_cnt_reg   <= ones_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            first_reg      <= first_next;
            se0_seen_reg   <= se0_seen_next;
            active_reg     <= active_next;
            valid_reg      <= valid_next;
            sop_reg        <= sop_next;
            eop_reg        <= eop_next;
            err_reg        <= err_next;
            data_reg       <= data_next;
        end
    end

    assign rx.rx_active = active_reg;
    assign rx.rx_valid  = valid_reg;
    assign rx.rx_sop    = sop_reg;
    assign rx.rx_eop    = eop_reg;
    assign rx.rx_err    = err_reg;
    assign rx.rx_data   = data_reg;

endmodule

// File: tb/tb_phy_rx.sv
// tb_phy_rx: self-checking bench for phy_rx.
//   A small bit-level transmitter (NRZI + bit stuffing) drives the line; each
//   test pushes the events it expects into a scoreboard queue and a monitor
//   compares every rx_valid/rx_err event against the queue head.
`timescale 1ns/1ps
module tb_phy_rx;
    import phy_pkg::*;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    logic r_d0;
    logic r_d1;

    always #5 clk = ~clk;

    phy_rx_if rx_if ();

    phy_rx #(
        .CLK_PER_BIT    (CPB),
        .SYNC_MIN_ZEROS (6)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .r_d0 (r_d0),
        .r_d1 (r_d1),
        .rx   (rx_if)
    );

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } ev_t;

    ev_t   exp_q[$];
    ev_t   mon_act;
    ev_t   mon_exp;
    int    assert_cnt = 0;
    int    fail_cnt   = 0;
    line_t tx_line;
    int    tx_ones;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && (rx_if.rx_valid === 1'b1 || rx_if.rx_err === 1'b1)) begin
            mon_act.valid = rx_if.rx_valid;
            mon_act.data  = (rx_if.rx_valid === 1'b1) ? rx_if.rx_data : 8'h00;
            mon_act.sop   = rx_if.rx_sop;
            mon_act.eop   = rx_if.rx_eop;
            mon_act.err   = rx_if.rx_err;
            assert_cnt++;
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL scoreboard_unexpected: actual valid=%0b data=%02h sop=%0b eop=%0b err=%0b required no event",
                         mon_act.valid, mon_act.data, mon_act.sop, mon_act.eop, mon_act.err);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    fail_cnt++;
                    $display("FAIL scoreboard_event: actual valid=%0b data=%02h sop=%0b eop=%0b err=%0b required valid=%0b data=%02h sop=%0b eop=%0b err=%0b",
                             mon_act.valid, mon_act.data, mon_act.sop, mon_act.eop, mon_act.err,
                             mon_exp.valid, mon_exp.data, mon_exp.sop, mon_exp.eop, mon_exp.err);
                end else begin
                    $display("rx event t=%0t valid=%0b data=%02h sop=%0b eop=%0b err=%0b ok",
                             $time, mon_act.valid, mon_act.data, mon_act.sop, mon_act.eop, mon_act.err);
                end
            end
        end
    end

    // ---------------- transmitter model ----------------
    task automatic push_ev(input logic v, input logic [7:0] d, input logic s,
                           input logic e, input logic r);
        ev_t x;
        x.valid = v;
        x.data  = d;
        x.sop   = s;
        x.eop   = e;
        x.err   = r;
        exp_q.push_back(x);
    endtask

    task automatic line_bit(input line_t st);
        r_d0 = st[1];
        r_d1 = st[0];
        repeat (CPB) @(negedge clk);
    endtask

    task automatic tx_raw(input logic b);
        if (!b) tx_line = (tx_line == LINE_J) ? LINE_K : LINE_J;
        line_bit(tx_line);
        tx_ones = b ? tx_ones + 1 : 0;
    endtask

    task automatic tx_data(input logic b);
        tx_raw(b);
        if (tx_ones == STUFF_LEN) tx_raw(1'b0);
    endtask

    task automatic tx_sync();
        tx_line = LINE_J;
        tx_ones = 0;
        repeat (7) tx_raw(1'b0);
        tx_raw(1'b1);
    endtask

    task automatic tx_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) tx_data(v[i]);
    endtask

    task automatic tx_eop();
        line_bit(LINE_SE0);
        line_bit(LINE_SE0);
        line_bit(LINE_J);
        tx_line = LINE_J;
    endtask

    task automatic idle(input int n);
        repeat (n) line_bit(LINE_J);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [12:0] outs;
        rst  = 1'b1;
        r_d0 = 1'b1;
        r_d1 = 1'b0;
        repeat (4) @(negedge clk);
        outs = {rx_if.rx_active, rx_if.rx_valid, rx_if.rx_sop, rx_if.rx_eop,
                rx_if.rx_err, rx_if.rx_data};
        assert_cnt++;
        if (outs !== 13'h0) begin
            fail_cnt++;
            $display("FAIL reset_outputs: actual=%04h required=0000", outs);
        end
        rst = 1'b0;
        idle(4);
        $display("test_reset done");
    endtask

    task automatic test_loopback();
        push_ev(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        push_ev(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        push_ev(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
        push_ev(1'b1, 8'hFC, 1'b0, 1'b1, 1'b0);
        tx_sync();
        tx_byte(8'h00);
        assert_cnt++;
        if (rx_if.rx_active !== 1'b1) begin
            fail_cnt++;
            $display("FAIL loopback_active: actual=%0b required=1", rx_if.rx_active);
        end
        tx_byte(8'hFF);
        tx_byte(8'h0F);
        tx_byte(8'hFC);
        tx_eop();
        idle(3);
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL loopback_drain: actual pending=%0d required=0", exp_q.size());
        end
        assert_cnt++;
        if (rx_if.rx_active !== 1'b0) begin
            fail_cnt++;
            $display("FAIL loopback_idle_active: actual=%0b required=0", rx_if.rx_active);
        end
        $display("test_loopback done");
    endtask

    task automatic test_single_stuff();
        push_ev(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        tx_sync();
        tx_byte(8'hFF);
        line_bit(LINE_SE0);
`ifdef RX_SYNC_FF_EN
        repeat (2) @(negedge clk);
`endif
        // Last byte appears one cycle after the first SE0 sample.
        assert_cnt++;
        if ({rx_if.rx_valid, rx_if.rx_eop} !== 2'b11) begin
            fail_cnt++;
            $display("FAIL single_eop_latency: actual valid=%0b eop=%0b required valid=1 eop=1",
                     rx_if.rx_valid, rx_if.rx_eop);
        end
        line_bit(LINE_SE0);
        line_bit(LINE_J);
        tx_line = LINE_J;
        idle(3);
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL single_drain: actual pending=%0d required=0", exp_q.size());
        end
        $display("test_single_stuff done");
    endtask

    task automatic test_stuff_error();
        push_ev(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
        push_ev(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        push_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tx_sync();
        tx_byte(8'hCC);
        tx_byte(8'hAA);
        tx_byte(8'h1F);
        // Fourth byte slot: seven unstuffed 1s, the stuff bit sent inverted.
        repeat (7) tx_raw(1'b1);
        line_bit(LINE_SE0);
        line_bit(LINE_SE0);
        assert_cnt++;
        if (rx_if.rx_active !== 1'b1) begin
            fail_cnt++;
            $display("FAIL err_active_before_j: actual=%0b required=1", rx_if.rx_active);
        end
        line_bit(LINE_J);
        tx_line = LINE_J;
        idle(2);
        assert_cnt++;
        if (rx_if.rx_active !== 1'b0) begin
            fail_cnt++;
            $display("FAIL err_active_after_j: actual=%0b required=0", rx_if.rx_active);
        end
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL err_drain: actual pending=%0d required=0", exp_q.size());
        end
        $display("test_stuff_error done");
    endtask

    task automatic test_misaligned_eop();
        push_ev(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1);
        tx_sync();
        tx_byte(8'hAA);
        tx_data(1'b1);
        tx_data(1'b0);
        tx_data(1'b1);
        tx_eop();
        idle(3);
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL misaligned_drain: actual pending=%0d required=0", exp_q.size());
        end
        $display("test_misaligned_eop done");
    endtask

    task automatic test_short_sync();
        tx_line = LINE_J;
        tx_ones = 0;
        repeat (4) tx_raw(1'b0);
        tx_raw(1'b1);
        assert_cnt++;
        if (rx_if.rx_active !== 1'b0) begin
            fail_cnt++;
            $display("FAIL short_sync_active: actual=%0b required=0", rx_if.rx_active);
        end
        idle(4);
        push_ev(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        tx_sync();
        tx_byte(8'h55);
        tx_eop();
        idle(3);
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL short_sync_drain: actual pending=%0d required=0", exp_q.size());
        end
        $display("test_short_sync done");
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0]  b1;
        logic [12:0] outs;
        b1 = 8'h5A;
        tx_sync();
        tx_byte(8'h3C);
        for (int i = 0; i < 4; i++) tx_data(b1[i]);
        rst  = 1'b1;
        r_d0 = 1'b1;
        r_d1 = 1'b0;
        @(negedge clk);
        outs = {rx_if.rx_active, rx_if.rx_valid, rx_if.rx_sop, rx_if.rx_eop,
                rx_if.rx_err, rx_if.rx_data};
        assert_cnt++;
        if (outs !== 13'h0) begin
            fail_cnt++;
            $display("FAIL midreset_outputs: actual=%04h required=0000", outs);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tx_line = LINE_J;
        idle(4);
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL midreset_pending: actual pending=%0d required=0", exp_q.size());
        end
        push_ev(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0);
        tx_sync();
        tx_byte(8'h0F);
        tx_eop();
        idle(3);
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL midreset_drain: actual pending=%0d required=0", exp_q.size());
        end
        $display("test_reset_mid_packet done");
    endtask

    initial begin
        rst     = 1'b1;
        r_d0    = 1'b1;
        r_d1    = 1'b0;
        tx_line = LINE_J;
        tx_ones = 0;
        @(negedge clk);
        test_reset();
        test_loopback();
        test_single_stuff();
        test_stuff_error();
        test_misaligned_eop();
        test_short_sync();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
